// File: rtl/set_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : set_arbiter
// Purpose  : Round-robin arbiter and job controller for two requesters that
//            share one set engine. A winner's job fields are latched and
//            handed to the engine. The controller waits for the engine
//            result, bounded by a watchdog. It then reports the result
//            back, tagged with the requester index.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            req0/1           - level requests, held until granted
//            central0/1       - 3 x {x[3:0], y[3:0]} circle centres
//            radius0/1        - 3 x 4-bit radii
//            mode0/1          - set-operation mode
//            gnt0/1           - one-cycle grant pulses
//            rsp_valid/id/candidate/err - one-cycle result report
//            ctrl_busy        - controller outside IDLE
//            eng_en           - one-cycle engine start
//            eng_central/radius/mode - latched job fields to the engine
//            eng_busy/valid/candidate - engine status and result
// Revision : 1.0 - initial release
// ============================================================================
module set_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] central0,
  input  logic [23:0] central1,
  input  logic [11:0] radius0,
  input  logic [11:0] radius1,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_candidate,
  output logic        rsp_err,
  output logic        ctrl_busy,
  output logic        eng_en,
  output logic [23:0] eng_central,
  output logic [11:0] eng_radius,
  output logic [1:0]  eng_mode,
  input  logic        eng_busy,
  input  logic        eng_valid,
  input  logic [7:0]  eng_candidate
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_ISSUE  = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;      // index granted most recently
  logic [7:0]  r_wd;        // watchdog, counts RUN cycles
  logic        w_win;       // arbitration winner index
  logic        w_capture;   // accept engine result this cycle

  logic        r_gnt0, r_gnt1, r_rsp_valid, r_rsp_id, r_rsp_err;
  logic        r_busy, r_eng_en;
  logic [7:0]  r_rsp_cand;
  logic [23:0] r_eng_central;
  logic [11:0] r_eng_radius;
  logic [1:0]  r_eng_mode;

  // The watchdog reads zero in the first RUN cycle only, so a valid that
  // lingers from a previous job is never mistaken for this job's result.
  assign w_capture = (r_state == S_RUN) && eng_valid && (r_wd != 8'd0);

  always_comb begin
    w_next = r_state;
    w_win  = (req0 && req1) ? ~r_last : req1;
    case (r_state)
      S_IDLE:   if (req0 || req1) w_next = S_GRANT;
      S_GRANT:  w_next = S_ISSUE;
      S_ISSUE:  w_next = S_RUN;
      S_RUN: begin
        if (w_capture)            w_next = S_DRAIN;
        else if (r_wd == TIMEOUT) w_next = S_REPORT;
      end
      S_DRAIN:  if (!eng_busy && !eng_valid) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;   // makes requester 0 the first winner
      r_wd          <= 8'd0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_cand    <= 8'd0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_eng_en      <= 1'b0;
      r_eng_central <= 24'd0;
      r_eng_radius  <= 12'd0;
      r_eng_mode    <= 2'd0;
    end else begin
      r_state     <= w_next;
      // Outputs are registered from the next state so each pulse lines up
      // exactly with the cycle spent in its state.
      r_eng_en    <= (w_next == S_ISSUE);
      r_rsp_valid <= (w_next == S_REPORT);
      r_busy      <= (w_next != S_IDLE);
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      if (r_state == S_IDLE && w_next == S_GRANT) begin
        r_gnt0        <= ~w_win;
        r_gnt1        <= w_win;
        r_last        <= w_win;
        r_rsp_id      <= w_win;
        r_eng_central <= w_win ? central1 : central0;
        r_eng_radius  <= w_win ? radius1  : radius0;
        r_eng_mode    <= w_win ? mode1    : mode0;
      end

      if (r_state == S_ISSUE) begin
        r_wd <= 8'd0;
      end else if (r_state == S_RUN && r_wd != TIMEOUT) begin
        r_wd <= r_wd + 8'd1;
      end

      if (w_capture) begin
        r_rsp_cand <= eng_candidate;
        r_rsp_err  <= 1'b0;
      end else if (r_state == S_RUN && r_wd == TIMEOUT) begin
        r_rsp_cand <= 8'd0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign gnt0          = r_gnt0;
  assign gnt1          = r_gnt1;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_candidate = r_rsp_cand;
  assign rsp_err       = r_rsp_err;
  assign ctrl_busy     = r_busy;
  assign eng_en        = r_eng_en;
  assign eng_central   = r_eng_central;
  assign eng_radius    = r_eng_radius;
  assign eng_mode      = r_eng_mode;

endmodule
`default_nettype wire
